// File: rtl/hf_subcarrier_rx.sv
// rtl/hf_subcarrier_rx.sv - ISO14443-A reader receive path: derivative filter, subcarrier detector, SSP serialiser, carrier gate.
// Optional latency timestamp FSM enabled by defining HF_RX_TIMESTAMP_EN.
module hf_subcarrier_rx #(
   parameter int ADC_W       = 8,
   parameter int SC_PERIOD   = 16,
   parameter int FRAME_BITS  = 8,
   parameter int RESET_PHASE = 3,
   parameter int EDGE_THRESH = 40,
   parameter int TS_W        = 16
) (
   input  logic            ck_1356meg,
   input  logic            rst,
   input  logic [ADC_W-1:0] adc_d,
   input  logic [2:0]      mod_type,
   input  logic            ssp_dout,
   output logic            ssp_clk,
   output logic            ssp_frame,
   output logic            ssp_din,
   output logic            pwr_hi_en,
   output logic            curbit,
   output logic [TS_W-1:0] ts_count,
   output logic            ts_valid
);
   localparam int FRAME_LEN = SC_PERIOD * FRAME_BITS;
   localparam int PH_W      = $clog2(FRAME_LEN);
   localparam int WIN_W     = $clog2(SC_PERIOD);
   localparam int F_W       = ADC_W + 3;

   localparam logic [WIN_W-1:0] WIN_EVAL   = WIN_W'(RESET_PHASE);
   localparam logic [WIN_W-1:0] WIN_HALF   = WIN_W'(SC_PERIOD / 2);
   localparam logic [PH_W-1:0]  PH_FRM_ON  = PH_W'(SC_PERIOD / 2 - 1);
   localparam logic [PH_W-1:0]  PH_FRM_OFF = PH_W'(SC_PERIOD / 2 - 1 + SC_PERIOD);
   localparam logic signed [F_W-1:0] THR_POS = F_W'(EDGE_THRESH);
   localparam logic signed [F_W-1:0] THR_NEG = F_W'(-EDGE_THRESH);
   localparam logic [2:0] MODE_READER_LISTEN = 3'd3;
   localparam logic [2:0] MODE_READER_MOD    = 3'd4;

   logic [PH_W-1:0]  phase;
   logic [WIN_W-1:0] win;
   logic [ADC_W-1:0] p1, p2, p3, p4;
   logic [F_W-1:0]   f_pos, f_neg;
   logic signed [F_W-1:0] f, fall_max, rise_min;
   logic             mod_r;
   logic [2:0]       mode_r;

   assign win = phase[WIN_W-1:0];

   // Both halves are at most 3*(2^ADC_W-1), so the difference fits ADC_W+3 signed bits.
   assign f_pos = {2'b00, p4, 1'b0} + {3'b000, p3};
   assign f_neg = {2'b00, adc_d, 1'b0} + {3'b000, p1};
   assign f     = $signed(f_pos - f_neg);

   // Carrier gate follows the mode and pause request as seen one cycle ago.
   assign pwr_hi_en = (mode_r == MODE_READER_MOD)    ? ~mod_r :
                      (mode_r == MODE_READER_LISTEN) ? 1'b1   : 1'b0;

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         phase     <= '0;
         p1        <= '0;
         p2        <= '0;
         p3        <= '0;
         p4        <= '0;
         fall_max  <= '0;
         rise_min  <= '0;
         curbit    <= 1'b0;
         mod_r     <= 1'b0;
         mode_r    <= 3'd0;
         ssp_clk   <= 1'b0;
         ssp_frame <= 1'b0;
         ssp_din   <= 1'b0;
      end else begin
         phase  <= phase + 1'b1;
         p1     <= adc_d;
         p2     <= p1;
         p3     <= p2;
         p4     <= p3;
         mod_r  <= ssp_dout;
         mode_r <= mod_type;

         if (win == WIN_EVAL) begin
            curbit   <= (fall_max > THR_POS) && (rise_min < THR_NEG);
            fall_max <= '0;
            rise_min <= '0;
         end else begin
            if (f > 0 && f > fall_max)
               fall_max <= f;
            if (f <= 0 && f < rise_min)
               rise_min <= f;
         end

         if (win == '0) begin
            ssp_clk <= 1'b1;
            ssp_din <= (mod_type == MODE_READER_LISTEN) ? curbit : 1'b0;
         end else if (win == WIN_HALF) begin
            ssp_clk <= 1'b0;
         end

         if (phase == PH_FRM_ON)
            ssp_frame <= 1'b1;
         else if (phase == PH_FRM_OFF)
            ssp_frame <= 1'b0;
      end
   end

`ifdef HF_RX_TIMESTAMP_EN
   typedef enum logic {TS_IDLE, TS_COUNT} ts_state_t;

   ts_state_t       ts_state;
   logic            mod_prev;
   logic [TS_W-1:0] ts_cnt;
   logic            mod_rise;

   assign mod_rise = mod_r & ~mod_prev;

   // A new pause restarts the measurement even if the tag answered in the same cycle.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         ts_state <= TS_IDLE;
         mod_prev <= 1'b0;
         ts_cnt   <= '0;
         ts_count <= '0;
         ts_valid <= 1'b0;
      end else begin
         mod_prev <= mod_r;
         ts_valid <= 1'b0;
         case (ts_state)
            TS_IDLE: begin
               if (mod_rise) begin
                  ts_cnt   <= '0;
                  ts_state <= TS_COUNT;
               end
            end
            TS_COUNT: begin
               if (mod_rise) begin
                  ts_cnt <= '0;
               end else if (curbit) begin
                  ts_count <= ts_cnt;
                  ts_valid <= 1'b1;
                  ts_state <= TS_IDLE;
               end else if (ts_cnt != '1) begin
                  ts_cnt <= ts_cnt + 1'b1;
               end
            end
            default: ts_state <= TS_IDLE;
         endcase
      end
   end
`else
   assign ts_count = '0;
   assign ts_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hf_subcarrier_rx.sv
// tb/tb_hf_subcarrier_rx.sv - randomized bench for hf_subcarrier_rx against a window-level reference model.
module tb_hf_subcarrier_rx;
   localparam int SC = 16;
   localparam int FB = 8;
   localparam int RP = 3;
   localparam int TH = 40;

   logic       clk;
   logic       rst;
   logic [7:0] adc_d;
   logic [2:0] mod_type;
   logic       ssp_dout;
   logic       ssp_clk, ssp_frame, ssp_din, pwr_hi_en, curbit, ts_valid;
   logic [15:0] ts_count;
   logic       ssp_clk4, ssp_frame4, ssp_din4, pwr_hi_en4, curbit4, ts_valid4;
   logic [3:0] ts_count4;

   int errors = 0;
   int checks = 0;

   hf_subcarrier_rx u_dut (
      .ck_1356meg(clk), .rst(rst), .adc_d(adc_d), .mod_type(mod_type), .ssp_dout(ssp_dout),
      .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din), .pwr_hi_en(pwr_hi_en),
      .curbit(curbit), .ts_count(ts_count), .ts_valid(ts_valid)
   );

   hf_subcarrier_rx #(.TS_W(4)) u_dut_ts4 (
      .ck_1356meg(clk), .rst(rst), .adc_d(adc_d), .mod_type(mod_type), .ssp_dout(ssp_dout),
      .ssp_clk(ssp_clk4), .ssp_frame(ssp_frame4), .ssp_din(ssp_din4), .pwr_hi_en(pwr_hi_en4),
      .curbit(curbit4), .ts_count(ts_count4), .ts_valid(ts_valid4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: window extremes, frame position, timestamp as plain integers.
   int m_phase, m_wmax, m_wmin, m_cur, m_modr, m_modprev, m_mode_r;
   int m_din, m_clk, m_frame, m_busy, m_cnt, m_ts16, m_ts4, m_tsv;
   int m_hist[4];
   int ts_en;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int f, win, rising, old_cur;
      if (rst) begin
         m_phase = 0; m_wmax = 0; m_wmin = 0; m_cur = 0; m_modr = 0; m_modprev = 0;
         m_mode_r = 0; m_din = 0; m_clk = 0; m_frame = 0; m_busy = 0; m_cnt = 0;
         m_ts16 = 0; m_ts4 = 0; m_tsv = 0;
         for (int i = 0; i < 4; i++) m_hist[i] = 0;
         return;
      end
      f = 2 * m_hist[3] + m_hist[2] - 2 * int'(adc_d) - m_hist[0];
      win = m_phase % SC;
      rising = (m_modr == 1 && m_modprev == 0);
      old_cur = m_cur;
      if (win == RP) begin
         m_cur = (m_wmax > TH && m_wmin < -TH) ? 1 : 0;
         m_wmax = 0;
         m_wmin = 0;
      end else begin
         if (f > m_wmax) m_wmax = f;
         if (f < m_wmin) m_wmin = f;
      end
      m_tsv = 0;
      if (rising) begin
         m_busy = 1; m_cnt = 0;
      end else if (m_busy == 1 && old_cur == 1) begin
         m_busy = 0; m_tsv = 1;
         m_ts16 = (m_cnt > 65535) ? 65535 : m_cnt;
         m_ts4  = (m_cnt > 15) ? 15 : m_cnt;
      end else if (m_busy == 1) begin
         m_cnt++;
      end
      if (win == 0) m_din = (mod_type == 3'd3) ? old_cur : 0;
      if (win == 0) m_clk = 1;
      else if (win == SC / 2) m_clk = 0;
      if (m_phase == SC / 2 - 1) m_frame = 1;
      else if (m_phase == SC / 2 - 1 + SC) m_frame = 0;
      m_modprev = m_modr;
      m_modr = int'(ssp_dout);
      m_mode_r = int'(mod_type);
      m_phase = (m_phase + 1) % (SC * FB);
      m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0];
      m_hist[0] = int'(adc_d);
   endtask

   task automatic step();
      int exp_pwr;
      model_step();
      @(posedge clk);
      #1;
      exp_pwr = (m_mode_r == 4) ? (1 - m_modr) : ((m_mode_r == 3) ? 1 : 0);
      check("ssp_clk", int'(ssp_clk), m_clk);
      check("ssp_frame", int'(ssp_frame), m_frame);
      check("ssp_din", int'(ssp_din), m_din);
      check("pwr_hi_en", int'(pwr_hi_en), exp_pwr);
      check("curbit", int'(curbit), m_cur);
      check("ts_valid", int'(ts_valid), ts_en * m_tsv);
      check("ts_count", int'(ts_count), ts_en * m_ts16);
      check("ts_valid_w4", int'(ts_valid4), ts_en * m_tsv);
      check("ts_count_w4", int'(ts_count4), ts_en * m_ts4);
      check("curbit_w4", int'(curbit4), m_cur);
   endtask

   int sq_t;
   task automatic square(input int lo, input int hi, input int n);
      for (int i = 0; i < n; i++) begin
         adc_d = ((sq_t / 8) % 2 == 1) ? 8'(hi) : 8'(lo);
         sq_t++;
         step();
      end
   endtask

   task automatic constant(input int v, input int n);
      adc_d = 8'(v);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int zeros, seen, seen_ts4, amp, base, style;
`ifdef HF_RX_TIMESTAMP_EN
      ts_en = 1;
`else
      ts_en = 0;
`endif
      sq_t = 0;
      rst = 1'b1; adc_d = 8'hFF; mod_type = 3'd3; ssp_dout = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("rst_outputs", int'({ssp_clk, ssp_frame, ssp_din, pwr_hi_en, curbit, ts_valid}), 0);
      check("rst_ts_count", int'(ts_count), 0);
      rst = 1'b0;
      step();
      check("first_clk_rise", int'(ssp_clk), 1);

      square(8'h20, 8'hA0, 64);
      check("sq_curbit", int'(curbit), 1);
      check("sq_ssp_din", int'(ssp_din), 1);
      constant(8'h80, 160);
      check("flat_curbit", int'(curbit), 0);
      check("flat_ssp_din", int'(ssp_din), 0);

      mod_type = 3'd4;
      step();
      zeros = 0;
      ssp_dout = 1'b1;
      for (int i = 0; i < 40; i++) begin step(); if (!pwr_hi_en) zeros++; end
      ssp_dout = 1'b0;
      for (int i = 0; i < 10; i++) begin step(); if (!pwr_hi_en) zeros++; end
      check("pause_len", zeros, 40);
      mod_type = 3'd2;
      ssp_dout = 1'b1;
      constant(8'h80, 20);
      check("tagmod_pwr", int'(pwr_hi_en), 0);
      ssp_dout = 1'b0;

      mod_type = 3'd3;
      constant(8'h80, 40);
      ssp_dout = 1'b1;
      step();
      ssp_dout = 1'b0;
      seen = 0; seen_ts4 = -1;
      adc_d = 8'h80;
      for (int i = 0; i < 60; i++) begin step(); if (ts_valid) seen++; end
      for (int i = 0; i < 64; i++) begin
         adc_d = ((sq_t / 8) % 2 == 1) ? 8'hA0 : 8'h20;
         sq_t++;
         step();
         if (ts_valid) begin seen++; seen_ts4 = int'(ts_count4); end
      end
      check("ts_pulses", seen, ts_en);
      if (seen == 1) check("ts_sat_w4", seen_ts4, 15);

      square(8'h80, 8'h80 + 13, 64);
      check("amp13_curbit", int'(curbit), 0);
      square(8'h80, 8'h80 + 14, 64);
      check("amp14_curbit", int'(curbit), 1);

      for (int blk = 0; blk < 24; blk++) begin
         mod_type = 3'($urandom_range(0, 7));
         style = $urandom_range(0, 2);
         amp = $urandom_range(0, 60);
         base = $urandom_range(0, 255 - amp);
         for (int i = 0; i < 150; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) ssp_dout = ~ssp_dout;
            if (style == 0) adc_d = 8'($urandom_range(0, 255));
            else if (style == 1) adc_d = ((sq_t / 8) % 2 == 1) ? 8'(base + amp) : 8'(base);
            else adc_d = 8'(base);
            sq_t++;
            step();
         end
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hf_subcarrier_rx.md
Name: hf_subcarrier_rx

Overview:
- Parametrised reader-side ISO14443-A receive/transmit-timing block for the HF FPGA image, clocked by the 13.56 MHz carrier.
- Filters ADC samples with a 5-tap derivative filter and detects subcarrier load modulation once per subcarrier window.
- Serialises detected bits to the ARM over SSP (clock, frame, data) and gates the carrier for reader pauses.
- Adds a latency timestamp: counts carrier cycles from start of reader modulation to first detected tag modulation.

Parameters:
- ADC_W, 8, ADC sample width (bits).
- SC_PERIOD, 16, carrier cycles per detection window and per SSP bit; power of two, 4..64.
- FRAME_BITS, 8, SSP bits per frame; power of two, 2..16.
- RESET_PHASE, 3, window phase (0..SC_PERIOD-1) at which the detector evaluates and clears.
- EDGE_THRESH, 40, edge magnitude threshold; strictly-greater comparison.
- TS_W, 16, timestamp counter width.

Ports:
- ck_1356meg  in  1  carrier clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- adc_d  in  ADC_W  unsigned ADC sample.
- mod_type  in  3  0 SNIFFER, 1 TAGSIM_LISTEN, 2 TAGSIM_MOD, 3 READER_LISTEN, 4 READER_MOD, others reserved.
- ssp_dout  in  1  modulation request from ARM; 1 = pause.
- ssp_clk  out  1  SSP clock to ARM.
- ssp_frame  out  1  SSP frame strobe.
- ssp_din  out  1  SSP data to ARM.
- pwr_hi_en  out  1  carrier enable; top level ANDs it with the carrier.
- curbit  out  1  last window's modulation decision.
- ts_count  out  TS_W  latched latency in carrier cycles.
- ts_valid  out  1  one-cycle pulse when ts_count updates.

Behaviour:
- Reset: all outputs 0; phase counter 0; sample history 0; edge maxima 0; timestamp idle.
- Phase counter: log2(SC_PERIOD*FRAME_BITS) bits, increments every cycle, wraps from SC_PERIOD*FRAME_BITS-1 to 0.
- win = phase mod SC_PERIOD.
- Sample history: 4-deep shift register p1..p4, p1 newest.
- Filter, combinational on the current sample: f = (2*p4 + p3) - (2*adc_d + p1).
  - Operands zero-extended.
  - f is signed, ADC_W+3 bits; no overflow possible.
- Detector, at win==RESET_PHASE:
  - curbit <= (fall_max > EDGE_THRESH) && (rise_min < -EDGE_THRESH).
  - Clear fall_max and rise_min to 0.
- Detector, at any other win:
  - If f>0 and f>fall_max, fall_max <= f.
  - If f<=0 and f<rise_min, rise_min <= f.
- mod_r <= ssp_dout, registered every cycle.
- pwr_hi_en:
  - READER_MOD: ~mod_r.
  - READER_LISTEN: 1.
  - All other modes: 0.
- SSP clock: ssp_clk <= 1 at win==0 and <= 0 at win==SC_PERIOD/2, giving a 50% duty clock.
- SSP frame:
  - ssp_frame <= 1 at phase==SC_PERIOD/2-1.
  - ssp_frame <= 0 at phase==SC_PERIOD/2-1+SC_PERIOD.
- SSP data: at win==0, ssp_din <= curbit when mod_type==READER_LISTEN, else 0. ssp_din holds between updates.
- Timestamp FSM, states IDLE, COUNT:
  - IDLE -> COUNT on rising edge of mod_r (mod_r=1, previous 0). Counter cleared to 0.
  - COUNT: increments by 1 per cycle and saturates at 2^TS_W-1.
  - Rising mod_r while in COUNT restarts the counter at 0.
  - COUNT -> IDLE on the first cycle curbit==1 (evaluated after the register update):
    - ts_count <= counter;
    - ts_valid pulses for 1 cycle.
  - Restart and stop in the same cycle: restart wins, no ts_valid.
  - ts_count holds its value in IDLE.
- mod_type change: takes effect next cycle; detector and phase are not disturbed.
- Reserved mod_type values behave as SNIFFER.
- Reset mid-frame: ssp_clk and ssp_frame drop to 0 the next cycle; no partial-frame completion.

Optional Feature:
- Macro HF_RX_TIMESTAMP_EN.
- Defined: timestamp FSM present as specified.
- Undefined: FSM omitted; ts_count tied 0 and ts_valid tied 0; all other behaviour identical.

Test Plan:
1. rst=1 for 3 cycles with adc_d=8'hFF -> every output 0; first ssp_clk rise 1 cycle after rst falls; ssp_frame high on cycles 7..22 of the 128-cycle frame.
2. READER_LISTEN, adc_d square wave 0x20/0xA0 with 8-cycle half-period -> curbit=1 at the next win==3; ssp_din=1 from the following win==0.
3. READER_LISTEN, adc_d constant 0x80 -> f=0 always, curbit=0, ssp_din=0 for all 8 frame bits.
4. READER_MOD, ssp_dout pulse 1 for 40 cycles -> pwr_hi_en=0 for exactly 40 cycles, delayed 1 cycle. Mode 2 -> pwr_hi_en stays 0.
5. Timestamp: ssp_dout rises, tag square wave begins so curbit rises 37 cycles later -> ts_valid pulse with ts_count=37. With TS_W=4 and no tag response -> counter holds at 15, no ts_valid.
6. Modulation stimulus with amplitude ±13 on adc_d (|f|=39, below EDGE_THRESH) -> curbit=0. With amplitude ±14 (|f|=42) -> curbit=1.
